// File: rtl/score_pkg.sv
// Shared types and defaults for the score-increment pulse generator.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } pulse_state_t;

  localparam int unsigned DEFAULT_GAP_CYCLES = 2;
  localparam int unsigned DEFAULT_PEND_W     = 3;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector; shared by the pass-event and flap-button paths.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/score_pulse_gen.sv
// Turns pass events into spaced single-cycle score increments with a saturating backlog.
// Optional SCORE_BONUS_EN adds a bonus input: a rise with bonus=1 queues two points.
module score_pulse_gen
  import score_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int unsigned PEND_W     = DEFAULT_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_over,
  input  logic              pass_event,
`ifdef SCORE_BONUS_EN
  input  logic              bonus,
`endif
  output logic              incr_out,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned SUM_W = PEND_W + 2;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  pulse_state_t     state, next_state;
  logic [CNT_W-1:0] gap_cnt;
  logic             rise;
  logic             issue;
  logic [SUM_W-1:0] add, sum;
  logic             sat;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (pass_event),
    .rise (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      incr_out <= 1'b0;
    end else begin
      state    <= next_state;
      incr_out <= (next_state == PULSE);
    end
  end

  // A finished gap with work queued goes straight to PULSE so a backlog
  // drains at one pulse per GAP_CYCLES+1 cycles.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending != '0) begin
          next_state = PULSE;
          issue      = 1'b1;
        end
      end
      PULSE: next_state = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (pending != '0) begin
            next_state = PULSE;
            issue      = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    if (game_over) begin
      next_state = IDLE;
      issue      = 1'b0;
    end
  end

  always_comb begin
    busy = (state != IDLE) || (pending != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  gap_cnt <= '0;
    else if (state == GAP && next_state == GAP) gap_cnt <= gap_cnt + CNT_W'(1);
    else                                      gap_cnt <= '0;
  end

  always_comb begin
    add = '0;
    if (rise) begin
`ifdef SCORE_BONUS_EN
      add = bonus ? SUM_W'(2) : SUM_W'(1);
`else
      add = SUM_W'(1);
`endif
    end
    sum = SUM_W'(pending) + add - SUM_W'(issue);
    sat = (sum > SUM_W'(PEND_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (game_over) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= sat ? PEND_MAX : sum[PEND_W-1:0];
      if (sat) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_pulse_gen.sv
// Directed bench for score_pulse_gen: default instance plus a long-gap instance for saturation.
module tb_score_pulse_gen;

  logic       clk = 1'b0;
  logic       rst, game_over, pass_event, game_over_g, pass_g;
  logic       incr_out, busy, overflow, incr_g, busy_g, overflow_g;
  logic [2:0] pending, pending_g;
`ifdef SCORE_BONUS_EN
  logic       bonus, bonus_g;
  logic       bcd_clr;
  logic [3:0] ones, tens;
`endif

  int unsigned checks = 0, failures = 0;
  int unsigned cyc = 0, n_a = 0, n_g = 0;
  int unsigned pulse_cyc[$];

  always #5 clk = ~clk;

  score_pulse_gen #(.GAP_CYCLES(2), .PEND_W(3)) u_dut (
    .clk(clk), .rst(rst), .game_over(game_over), .pass_event(pass_event),
`ifdef SCORE_BONUS_EN
    .bonus(bonus),
`endif
    .incr_out(incr_out), .pending(pending), .busy(busy), .overflow(overflow)
  );

  score_pulse_gen #(.GAP_CYCLES(20), .PEND_W(3)) u_gap (
    .clk(clk), .rst(rst), .game_over(game_over_g), .pass_event(pass_g),
`ifdef SCORE_BONUS_EN
    .bonus(bonus_g),
`endif
    .incr_out(incr_g), .pending(pending_g), .busy(busy_g), .overflow(overflow_g)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (incr_out === 1'b1) begin
      n_a <= n_a + 1;
      pulse_cyc.push_back(cyc);
    end
    if (incr_g === 1'b1) n_g <= n_g + 1;
  end

`ifdef SCORE_BONUS_EN
  // Two-digit BCD score counter standing in for the display chain.
  always @(posedge clk) begin
    if (bcd_clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (incr_out) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned base, qb, peak;
    rst = 1'b1; game_over = 1'b0; pass_event = 1'b0; game_over_g = 1'b0; pass_g = 1'b0;
`ifdef SCORE_BONUS_EN
    bonus = 1'b0; bonus_g = 1'b0; bcd_clr = 1'b1;
`endif

    // Reset held 3 cycles, then released.
    repeat (3) tick;
    check("rst_incr", incr_out, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick;
    check("post_rst_incr", incr_out, 0);
    check("post_rst_busy", busy, 0);

    // Level held 5 cycles -> one pulse, two edges after the rise edge.
    base = n_a;
    pass_event = 1'b1;
    tick;
    check("lvl_pending1", pending, 1);
    check("lvl_incr_early", incr_out, 0);
    check("lvl_busy", busy, 1);
    tick;
    check("lvl_incr", incr_out, 1);
    check("lvl_pending0", pending, 0);
    tick;
    check("lvl_incr_width", incr_out, 0);
    tick; tick;
    pass_event = 1'b0;
    repeat (4) tick;
    check("lvl_pulses", n_a - base, 1);
    check("lvl_idle_busy", busy, 0);

    // Three rises two cycles apart -> pulses three cycles apart.
    qb = pulse_cyc.size();
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      pass_event = (i % 2 == 0);
      tick;
      if (pending > peak) peak = pending;
    end
    tick; tick;
    check("spc_third_incr", incr_out, 1);
    tick; tick;
    check("spc_busy_gap", busy, 1);
    tick;
    check("spc_busy_done", busy, 0);
    check("spc_peak", peak, 1);
    check("spc_count", pulse_cyc.size() - qb, 3);
    if (pulse_cyc.size() - qb == 3) begin
      check("spc_d1", pulse_cyc[qb+1] - pulse_cyc[qb], 3);
      check("spc_d2", pulse_cyc[qb+2] - pulse_cyc[qb+1], 3);
    end

    // Long gap: nine rises saturate the backlog at 7 and drop one point.
    base = n_g;
    for (int i = 0; i < 18; i++) begin
      pass_g = (i % 2 == 0);
      tick;
    end
    check("sat_pending", pending_g, 7);
    check("sat_overflow", overflow_g, 1);
    repeat (200) tick;
    check("sat_pulses", n_g - base, 8);
    check("sat_drained", pending_g, 0);
    check("sat_sticky", overflow_g, 1);

    // Backlog then game_over mid-PULSE with pass_event held through its fall.
    base = n_a;
    for (int i = 0; i < 10; i++) begin
      pass_event = (i % 2 == 0);
      tick;
    end
    tick;
    check("go_mid_pulse", incr_out, 1);
    check("go_backlog", pending, 1);
    game_over = 1'b1; game_over_g = 1'b1; pass_event = 1'b1;
    tick;
    check("go_incr", incr_out, 0);
    check("go_pending", pending, 0);
    check("go_busy", busy, 0);
    check("go_ovf_clear", overflow_g, 0);
    check("go_pend_g", pending_g, 0);
    game_over = 1'b0; game_over_g = 1'b0;
    repeat (6) tick;
    pass_event = 1'b0;
    tick;
    check("go_pulses", n_a - base, 4);
    check("go_held_level", pending, 0);

    // Async reset mid-pulse drops incr_out immediately; nothing follows release.
    pass_event = 1'b1;
    tick;
    pass_event = 1'b0;
    tick;
    check("ar_incr_before", incr_out, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_incr_async", incr_out, 0);
    check("ar_pending", pending, 0);
    tick;
    rst = 1'b0;
    base = n_a;
    repeat (6) tick;
    check("ar_no_pulse", n_a - base, 0);
    check("ar_busy", busy, 0);

`ifdef SCORE_BONUS_EN
    // Bonus rise queues two points that reach the BCD chain as score 02.
    bcd_clr = 1'b1;
    tick;
    bcd_clr = 1'b0;
    qb = pulse_cyc.size();
    pass_event = 1'b1; bonus = 1'b1;
    tick;
    check("bn_pending", pending, 2);
    pass_event = 1'b0; bonus = 1'b0;
    repeat (8) tick;
    check("bn_count", pulse_cyc.size() - qb, 2);
    if (pulse_cyc.size() - qb == 2)
      check("bn_spacing", pulse_cyc[qb+1] - pulse_cyc[qb], 3);
    check("bn_score", {tens, ones}, 8'h02);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
